multi_adc_capture: RTL and testbench

- Successor to the single-channel SIPO capture path.
- Drives one shared SPI-style chip-select and serial clock to NUM_CH serial ADCs, and deserialises all data lines in parallel.
- Stores frames (one sample per channel) in an internal circular buffer, in continuous or threshold-triggered mode.
- Streams the captured record out through a valid/ready port, for the UART packetiser to consume.

---
 rtl/multi_adc_capture.sv | 137 +++++++++++++
 tb/tb_multi_adc_capture.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_adc_capture.sv
// multi_adc_capture: drives a shared cs/sclk to NUM_CH serial ADCs, buffers frames circularly
// (continuous or threshold-triggered) and streams the record out over valid/ready.
module multi_adc_capture #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 10,
    parameter int FRAME_BITS = 16,
    parameter int LSB_PAD    = 2,
    parameter int QUIET      = 2,
    parameter int CLK_DIV    = 7,
    parameter int DEPTH      = 256,
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] adc_miso,
    output logic              spi_sclk,
    output logic              spi_cs,
    input  logic              arm,
    input  logic              mode,
    input  logic [CW-1:0]     trig_ch,
    input  logic [DATA_W-1:0] threshold,
    input  logic [AW-1:0]     post_count,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [CW-1:0]     rd_ch
);
    localparam int HP = 2 * (FRAME_BITS + QUIET);
    localparam int PW = $clog2(HP);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, READOUT} state_t;
    state_t state, state_n;

    logic [DW-1:0] dv;
    logic [PW-1:0] ph, ph_n;
    logic [NUM_CH-1:0][DATA_W-1:0] sr, rd_frame;
    logic [NUM_CH-1:0][DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, ra, fa, pc, m_pc;
    logic [AW:0] fw, left;
    logic [DATA_W-1:0] prev, cur, m_thr;
    logic [CW-1:0] m_ch, ch;
    logic m_mode, fv, cap, tick, xfer, last_ch, last_w, trig;

    assign cap = state == CAPTURE || state == POST;
    assign tick = dv == DW'(CLK_DIV - 1);
    assign ph_n = ph == PW'(HP - 1) ? '0 : ph + 1'b1;
    assign cur = sr[m_ch];
    assign trig = fw != '0 && prev < m_thr && cur >= m_thr;
    assign xfer = rd_valid && rd_ready;
    assign last_ch = ch == CW'(NUM_CH - 1);
    assign last_w = xfer && last_ch && left == (AW+1)'(1);
    // wr_ptr - n is the oldest frame; in continuous mode this wraps back to 0
    assign fa = !rd_valid ? wr_ptr - fw[AW-1:0] : (xfer && last_ch) ? ra + 1'b1 : ra;
    assign rd_data = rd_frame[ch];
    assign rd_ch = ch;
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (arm) state_n = CAPTURE;
            CAPTURE: if (fv && (m_mode ? trig : fw == (AW+1)'(DEPTH - 1)))
                         state_n = m_mode && m_pc != '0 ? POST : READOUT;
            POST:    if (fv && pc == AW'(1)) state_n = READOUT;
            READOUT: if (last_w) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) if (fv) mem[wr_ptr] <= sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            spi_cs <= 1'b1;
            spi_sclk <= 1'b1;
            done <= 1'b0;
            rd_valid <= 1'b0;
            rd_frame <= '0;
            ch <= '0;
            fv <= 1'b0;
        end else begin
            state <= state_n;
            done <= last_w;
            fv <= cap && tick && ph == PW'(2 * FRAME_BITS - 2);
            if (cap) begin
                dv <= tick ? '0 : dv + 1'b1;
                if (tick) begin
                    ph <= ph_n;
                    spi_cs <= ph_n >= PW'(2 * FRAME_BITS);
                    spi_sclk <= ph_n >= PW'(2 * FRAME_BITS) || ph_n[0];
                    // only the data field is shifted in; leading and pad bits are skipped
                    if (!ph[0] && ph >= PW'(2 * (FRAME_BITS - DATA_W - LSB_PAD)) && ph < PW'(2 * (FRAME_BITS - LSB_PAD)))
                        for (int c = 0; c < NUM_CH; c++) sr[c] <= {sr[c][DATA_W-2:0], adc_miso[c]};
                end
            end
            if (state_n != CAPTURE && state_n != POST) begin
                spi_cs <= 1'b1;
                spi_sclk <= 1'b1;
            end
            if (state == IDLE && arm) begin
                m_mode <= mode;
                m_ch <= trig_ch;
                m_thr <= threshold;
                m_pc <= post_count;
                dv <= '0;
                ph <= '0;
                spi_cs <= 1'b0;
                spi_sclk <= 1'b0;
                wr_ptr <= '0;
                fw <= '0;
            end
            if (fv) begin
                wr_ptr <= wr_ptr + 1'b1;
                fw <= fw == (AW+1)'(DEPTH) ? fw : fw + 1'b1;
                prev <= cur;
                pc <= state == CAPTURE ? m_pc : pc - 1'b1;
            end
            if (state == READOUT) begin
                ra <= fa;
                rd_frame <= mem[fa];
                if (!rd_valid) begin
                    rd_valid <= 1'b1;
                    left <= fw;
                end else if (xfer) begin
                    ch <= last_ch ? '0 : ch + 1'b1;
                    if (last_ch) left <= left - 1'b1;
                    if (last_w) rd_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_adc_capture.sv
// tb_multi_adc_capture: ADC line models plus a frame-level model of which samples the
// record must contain; readout is scoreboarded every cycle.
module tb_multi_adc_capture;
    localparam int NCH = 2;
    localparam int DEPTH = 8;

    typedef struct { logic [9:0] d; logic c; } word_t;

    logic clk = 0, reset, arm, mode, rd_ready, spi_sclk, spi_cs, busy, done, rd_valid;
    logic [1:0] adc_miso;
    logic [0:0] trig_ch, rd_ch;
    logic [9:0] threshold, rd_data;
    logic [2:0] post_count;

    int n_cmp = 0, n_err = 0, scen = 0, falls = 0, v_cycles = 0, cyc = 0;
    int nf = 0, cf = 0, bi = 0, last_fall = 0;
    bit bp_en = 0, pcs = 1, pscl = 1, stall_prev = 0;
    logic [9:0] pd;
    logic pch;
    logic [15:0] w;
    word_t exp_q[$];
    logic [9:0] got[$];
    int periods[$];

    multi_adc_capture #(.NUM_CH(2), .DATA_W(10), .FRAME_BITS(16), .LSB_PAD(2), .QUIET(2),
                        .CLK_DIV(2), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .adc_miso(adc_miso), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
        .arm(arm), .mode(mode), .trig_ch(trig_ch), .threshold(threshold), .post_count(post_count),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_ch(rd_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] val(input int c, input int f);
        case (scen)
            0: return c == 0 ? 10'(f) : 10'(1023 - f);
            1: return c == 0 ? 10'(f) : (f < 12 ? 10'h100 : 10'h250);
            2: return c == 0 ? 10'(f) : 10'h0;
            default: return c == 0 ? 10'(f) : (f == 0 ? 10'h0 : 10'h7);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Record = first DEPTH frames, or the DEPTH frames ending post_count after the first trigger.
    task automatic build_exp(input bit md, input int tch, input int thr, input int pc);
        int last, first, t;
        word_t e;
        exp_q.delete();
        got.delete();
        v_cycles = 0;
        last = DEPTH - 1;
        if (md) begin
            t = 1;
            while (t < 1000 && !(val(tch, t - 1) < thr && val(tch, t) >= thr)) t++;
            last = t + pc;
        end
        first = last - DEPTH + 1 < 0 ? 0 : last - DEPTH + 1;
        for (int f = first; f <= last; f++)
            for (int c = 0; c < NCH; c++) begin
                e.d = val(c, f);
                e.c = c[0];
                exp_q.push_back(e);
            end
    endtask

    task automatic arm_task(input logic md, input logic tch, input logic [9:0] thr, input logic [2:0] pc);
        @(posedge clk);
        #1 arm = 1; mode = md; trig_ch = tch; threshold = thr; post_count = pc;
        falls = 0;
        periods.delete();
        @(posedge clk);
        #1 arm = 0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        bit seen = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({nm, "_done_seen"}, 32'(seen), 1);
    endtask

    // ADC models: shift out {4'hA, sample, 2'b11} MSB first, a new bit on each falling sclk
    initial begin
        adc_miso = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy) nf = 0;
            if (pcs && !spi_cs) begin
                if (nf > 0) periods.push_back(cyc - last_fall);
                last_fall = cyc;
                cf = nf;
                nf++;
                falls++;
                bi = 0;
            end
            if (pscl && !spi_sclk && !spi_cs && bi < 16) begin
                for (int c = 0; c < NCH; c++) begin
                    w = {4'hA, val(c, cf), 2'b11};
                    adc_miso[c] = w[15 - bi];
                end
                bi++;
            end
            pcs = spi_cs;
            pscl = spi_sclk;
        end
    end

    initial begin
        rd_ready = 1;
        forever begin
            @(posedge clk);
            #1 rd_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) stall_prev = 0;
        else begin
            if (stall_prev) begin
                n_cmp++;
                if (!rd_valid || rd_data !== pd || rd_ch !== pch) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b d=%0h ch=%0d required v=1 d=%0h ch=%0d",
                             rd_valid, rd_data, rd_ch, pd, pch);
                end
            end
            if (rd_valid) v_cycles++;
            if (rd_valid && rd_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_word: got d=%0h ch=%0d required no word", rd_data, rd_ch);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    if (rd_data !== e.d || rd_ch !== e.c) begin
                        n_err++;
                        $display("FAIL word: got d=%0h ch=%0d required d=%0h ch=%0d", rd_data, rd_ch, e.d, e.c);
                    end
                end
                got.push_back(rd_data);
            end
            stall_prev = rd_valid && !rd_ready;
            pd = rd_data;
            pch = rd_ch;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; arm = 0; mode = 0; trig_ch = 0; threshold = '0; post_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs", spi_cs, 1);
        check("rst_sclk", spi_sclk, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_ch", rd_ch, 0);
        @(posedge clk);
        #1 reset = 0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("idle_cs", spi_cs, 1);
        check("idle_sclk", spi_sclk, 1);
        check("idle_busy", busy, 0);
        check("idle_valid", rd_valid, 0);

        // continuous capture, with an ignored arm pulse mid-capture
        scen = 0;
        build_exp(0, 0, 0, 0);
        arm_task(0, 0, 10'h0, 3'd0);
        @(negedge clk);
        check("cont_busy", busy, 1);
        repeat (200) @(posedge clk);
        #1 arm = 1; mode = 1; trig_ch = 1; threshold = 10'h3FF; post_count = 0;
        @(posedge clk);
        #1 arm = 0;
        wait_done("cont", 3000);
        check("cont_falls", falls, 8);
        check("cont_nperiods", periods.size(), 7);
        foreach (periods[i]) check($sformatf("cont_period%0d", i), periods[i], 72);
        check("cont_words", got.size(), 16);
        check("cont_nobubble", v_cycles, 16);
        check("cont_missing", exp_q.size(), 0);
        if (got.size() == 16) begin
            check("cont_w0", got[0], 0);
            check("cont_w1", got[1], 10'h3FF);
            check("cont_w14", got[14], 7);
            check("cont_w15", got[15], 10'h3F8);
        end
        @(negedge clk);
        check("cont_done_pulse", done, 0);
        check("cont_end_busy", busy, 0);
        check("cont_end_cs", spi_cs, 1);
        check("cont_end_sclk", spi_sclk, 1);
        check("cont_end_valid", rd_valid, 0);

        // triggered capture with random backpressure
        scen = 1;
        bp_en = 1;
        build_exp(1, 1, 'h200, 3);
        arm_task(1, 1, 10'h200, 3'd3);
        wait_done("trig", 4000);
        bp_en = 0;
        check("trig_falls", falls, 16);
        check("trig_words", got.size(), 16);
        check("trig_missing", exp_q.size(), 0);
        if (got.size() == 16) begin
            check("trig_w0", got[0], 8);
            check("trig_w7", got[7], 10'h100);
            check("trig_w8", got[8], 12);
            check("trig_w9", got[9], 10'h250);
        end

        // threshold 0 never triggers; reset while capturing
        scen = 2;
        exp_q.delete();
        got.delete();
        arm_task(1, 1, 10'h0, 3'd0);
        repeat (360) @(posedge clk);
        @(negedge clk);
        check("thr0_busy", busy, 1);
        check("thr0_novalid", rd_valid, 0);
        check("thr0_running", 32'(falls > 1), 1);
        check("pre_reset_cs", spi_cs, 0);
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_cs", spi_cs, 1);
        check("midrst_sclk", spi_sclk, 1);
        check("midrst_busy", busy, 0);
        check("midrst_valid", rd_valid, 0);
        @(posedge clk);
        #1 reset = 0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_cs", spi_cs, 1);

        // early trigger, then re-arm on the done cycle
        scen = 3;
        build_exp(1, 1, 5, 1);
        arm_task(1, 1, 10'd5, 3'd1);
        wait_done("early", 1000);
        check("early_falls", falls, 3);
        check("early_words", got.size(), 6);
        check("early_missing", exp_q.size(), 0);
        if (got.size() == 6) begin
            check("early_w1", got[1], 0);
            check("early_w3", got[3], 7);
            check("early_w4", got[4], 2);
        end
        build_exp(1, 1, 5, 1);
        falls = 0;
        periods.delete();
        arm = 1;
        @(posedge clk);
        #1 arm = 0;
        @(negedge clk);
        check("rearm_busy", busy, 1);
        check("rearm_cs", spi_cs, 0);
        wait_done("rearm", 1000);
        check("rearm_falls", falls, 3);
        check("rearm_words", got.size(), 6);
        check("rearm_missing", exp_q.size(), 0);
        @(negedge clk);
        check("rearm_done_pulse", done, 0);
        check("rearm_end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
